reorder_buffer: RTL and testbench

- Circular reorder buffer that sits directly downstream of the issue stage and upstream of the register bank.
- Issue allocates one entry per cycle in program order and receives the entry tag for the reservation station.
- Results broadcast on the common data bus (CDB) mark entries ready.
- The oldest ready entry retires in order and drives one register-bank write per cycle.

---
 rtl/reorder_buffer.sv | 120 ++++++++++++
 tb/tb_reorder_buffer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: issue allocates at tail, CDB marks entries done, head retires one per cycle.
// Optional flush port enabled by defining ROB_FLUSH_EN; commit outputs are registered (1 edge after head is done).
module reorder_buffer #(
  parameter int DEPTH  = 8,
  parameter int TAG_W  = 3,
  parameter int REG_W  = 4,
  parameter int DATA_W = 16
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              alloc_valid,
  input  logic [REG_W-1:0]  alloc_dest,
  output logic              alloc_ready,
  output logic [TAG_W-1:0]  alloc_tag,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
`ifdef ROB_FLUSH_EN
  input  logic              flush,
`endif
  output logic              commit_valid,
  output logic [REG_W-1:0]  commit_dest,
  output logic [DATA_W-1:0] commit_data,
  output logic [TAG_W-1:0]  commit_tag,
  output logic [TAG_W:0]    count,
  output logic              empty
);

  localparam logic [TAG_W:0] LP_FULL = DEPTH[TAG_W:0];

  logic              r_busy [DEPTH];
  logic              r_done [DEPTH];
  logic [REG_W-1:0]  r_dest [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [TAG_W-1:0]  r_head;
  logic [TAG_W-1:0]  r_tail;
  logic [TAG_W:0]    r_count;
  logic              r_commit_valid;
  logic [REG_W-1:0]  r_commit_dest;
  logic [DATA_W-1:0] r_commit_data;
  logic [TAG_W-1:0]  r_commit_tag;

  logic w_flush;
  logic w_alloc_fire;
  logic w_commit_fire;

`ifdef ROB_FLUSH_EN
  assign w_flush = flush;
`else
  assign w_flush = 1'b0;
`endif

  // Full check uses only the pre-edge count: a same-cycle retire does not free a slot.
  assign alloc_ready   = (r_count != LP_FULL);
  assign alloc_tag     = r_tail;
  assign w_alloc_fire  = alloc_valid && alloc_ready;
  assign w_commit_fire = r_busy[r_head] && r_done[r_head];

  assign commit_valid = r_commit_valid;
  assign commit_dest  = r_commit_dest;
  assign commit_data  = r_commit_data;
  assign commit_tag   = r_commit_tag;
  assign count        = r_count;
  assign empty        = (r_count == '0);

  always_ff @(posedge clk1) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_busy[i] <= 1'b0;
        r_done[i] <= 1'b0;
        r_dest[i] <= '0;
        r_data[i] <= '0;
      end
      r_head         <= '0;
      r_tail         <= '0;
      r_count        <= '0;
      r_commit_valid <= 1'b0;
      r_commit_dest  <= '0;
      r_commit_data  <= '0;
      r_commit_tag   <= '0;
    end else if (w_flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_busy[i] <= 1'b0;
        r_done[i] <= 1'b0;
      end
      r_tail         <= r_head;
      r_count        <= '0;
      r_commit_valid <= 1'b0;
    end else begin
      // Write order matters: allocation overrides a CDB hit on the new tag,
      // and retirement overrides a repeat CDB hit on the head entry.
      if (cdb_valid && r_busy[cdb_tag]) begin
        r_done[cdb_tag] <= 1'b1;
        r_data[cdb_tag] <= cdb_data;
      end
      if (w_alloc_fire) begin
        r_busy[r_tail] <= 1'b1;
        r_done[r_tail] <= 1'b0;
        r_dest[r_tail] <= alloc_dest;
        r_data[r_tail] <= '0;
        r_tail         <= r_tail + 1'b1;
      end
      r_commit_valid <= w_commit_fire;
      if (w_commit_fire) begin
        r_commit_dest  <= r_dest[r_head];
        r_commit_data  <= r_data[r_head];
        r_commit_tag   <= r_head;
        r_busy[r_head] <= 1'b0;
        r_done[r_head] <= 1'b0;
        r_head         <= r_head + 1'b1;
      end
      case ({w_alloc_fire, w_commit_fire})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed self-checking bench for reorder_buffer (DEPTH=8); covers flush too when ROB_FLUSH_EN is defined.
module tb_reorder_buffer;

  logic        clk1 = 1'b0;
  logic        rst;
  logic        alloc_valid;
  logic [3:0]  alloc_dest;
  logic        alloc_ready;
  logic [2:0]  alloc_tag;
  logic        cdb_valid;
  logic [2:0]  cdb_tag;
  logic [15:0] cdb_data;
`ifdef ROB_FLUSH_EN
  logic        flush;
`endif
  logic        commit_valid;
  logic [3:0]  commit_dest;
  logic [15:0] commit_data;
  logic [2:0]  commit_tag;
  logic [3:0]  count;
  logic        empty;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk1 = ~clk1;

  reorder_buffer #(.DEPTH(8), .TAG_W(3), .REG_W(4), .DATA_W(16)) dut (
    .clk1         (clk1),
    .rst          (rst),
    .alloc_valid  (alloc_valid),
    .alloc_dest   (alloc_dest),
    .alloc_ready  (alloc_ready),
    .alloc_tag    (alloc_tag),
    .cdb_valid    (cdb_valid),
    .cdb_tag      (cdb_tag),
    .cdb_data     (cdb_data),
`ifdef ROB_FLUSH_EN
    .flush        (flush),
`endif
    .commit_valid (commit_valid),
    .commit_dest  (commit_dest),
    .commit_data  (commit_data),
    .commit_tag   (commit_tag),
    .count        (count),
    .empty        (empty)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk1);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic alloc_one(input logic [3:0] dest, input logic [2:0] exp_tag);
    alloc_valid = 1'b1;
    alloc_dest  = dest;
    chk("alloc_tag", alloc_tag, exp_tag);
    step();
    alloc_valid = 1'b0;
  endtask

  task automatic cdb_one(input logic [2:0] tag, input logic [15:0] data);
    cdb_valid = 1'b1;
    cdb_tag   = tag;
    cdb_data  = data;
    step();
    cdb_valid = 1'b0;
  endtask

  task automatic chk_commit(input string tag, input logic [2:0] t, input logic [3:0] d,
                            input logic [15:0] v);
    chk({tag, "_valid"}, commit_valid, 1'b1);
    chk({tag, "_tag"},   commit_tag,   t);
    chk({tag, "_dest"},  commit_dest,  d);
    chk({tag, "_data"},  commit_data,  v);
  endtask

  initial begin
    alloc_valid = 1'b0;
    alloc_dest  = '0;
    cdb_valid   = 1'b0;
    cdb_tag     = '0;
    cdb_data    = '0;
`ifdef ROB_FLUSH_EN
    flush       = 1'b0;
`endif
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;

    chk("rst_count",  count,        0);
    chk("rst_empty",  empty,        1);
    chk("rst_ready",  alloc_ready,  1);
    chk("rst_tag",    alloc_tag,    0);
    chk("rst_cvalid", commit_valid, 0);
    chk("rst_cdest",  commit_dest,  0);
    chk("rst_cdata",  commit_data,  0);
    chk("rst_ctag",   commit_tag,   0);

    // Out-of-order completion, in-order retirement
    alloc_one(4'd1, 3'd0);
    alloc_one(4'd2, 3'd1);
    alloc_one(4'd3, 3'd2);
    chk("t1_count", count, 3);
    cdb_one(3'd2, 16'h0022);
    chk("t1_nocommit_a", commit_valid, 0);
    cdb_one(3'd1, 16'h0011);
    chk("t1_nocommit_b", commit_valid, 0);
    cdb_one(3'd0, 16'h0033);
    chk("t1_head_cdb_no_commit", commit_valid, 0);
    step();
    chk_commit("t1_c0", 3'd0, 4'd1, 16'h0033);
    step();
    chk_commit("t1_c1", 3'd1, 4'd2, 16'h0011);
    step();
    chk_commit("t1_c2", 3'd2, 4'd3, 16'h0022);
    step();
    chk("t1_idle", commit_valid, 0);
    chk("t1_empty", empty, 1);

    // Full and wrap
    do_reset();
    for (int i = 0; i < 8; i++) alloc_one(4'(i + 1), 3'(i));
    chk("t2_full_count", count, 8);
    chk("t2_full_ready", alloc_ready, 0);
    chk("t2_full_tag", alloc_tag, 0);
    alloc_valid = 1'b1;
    alloc_dest  = 4'hF;
    step();
    alloc_valid = 1'b0;
    chk("t2_ninth_count", count, 8);
    chk("t2_ninth_tag", alloc_tag, 0);
    cdb_one(3'd0, 16'h00A0);
    chk("t2_still_full", alloc_ready, 0);
    step();
    chk_commit("t2_c0", 3'd0, 4'd1, 16'h00A0);
    chk("t2_count7", count, 7);
    chk("t2_ready_again", alloc_ready, 1);
    chk("t2_wrap_tag", alloc_tag, 0);

    // Alloc and commit on the same edge
    do_reset();
    for (int i = 0; i < 5; i++) alloc_one(4'(i + 1), 3'(i));
    cdb_one(3'd0, 16'h0055);
    chk("t3_count_pre", count, 5);
    alloc_one(4'd9, 3'd5);
    chk("t3_count_same", count, 5);
    chk_commit("t3_c0", 3'd0, 4'd1, 16'h0055);
    chk("t3_tail", alloc_tag, 6);

    // Alloc beats same-tag CDB; non-busy CDB dropped; last CDB write wins
    do_reset();
    alloc_valid = 1'b1;
    alloc_dest  = 4'd4;
    cdb_valid   = 1'b1;
    cdb_tag     = 3'd0;
    cdb_data    = 16'h0077;
    step();
    alloc_valid = 1'b0;
    cdb_valid   = 1'b0;
    alloc_one(4'd5, 3'd1);
    cdb_one(3'd6, 16'hFFFF);
    chk("t4_count", count, 2);
    chk("t4_no_commit", commit_valid, 0);
    chk("t4_tail", alloc_tag, 2);
    step();
    chk("t4_alloc_wins", commit_valid, 0);
    cdb_one(3'd1, 16'h0010);
    cdb_one(3'd1, 16'h0012);
    cdb_one(3'd0, 16'h0001);
    chk("t4_wait", commit_valid, 0);
    step();
    chk_commit("t4_c0", 3'd0, 4'd4, 16'h0001);
    step();
    chk_commit("t4_c1", 3'd1, 4'd5, 16'h0012);
    step();
    chk("t4_idle", commit_valid, 0);
    chk("t4_empty", empty, 1);

    // Reset while the head is about to commit
    do_reset();
    for (int i = 0; i < 4; i++) alloc_one(4'(i + 1), 3'(i));
    for (int i = 3; i >= 0; i--) cdb_one(3'(i), 16'(16'h0100 + i));
    chk("t5_pre_count", count, 4);
    do_reset();
    chk("t5_cvalid", commit_valid, 0);
    chk("t5_count", count, 0);
    chk("t5_empty", empty, 1);
    chk("t5_tag", alloc_tag, 0);
    step();
    chk("t5_no_late_commit", commit_valid, 0);

`ifdef ROB_FLUSH_EN
    do_reset();
    for (int i = 0; i < 4; i++) alloc_one(4'(i + 1), 3'(i));
    cdb_one(3'd0, 16'h00F0);
    flush       = 1'b1;
    alloc_valid = 1'b1;
    alloc_dest  = 4'd7;
    chk("t6_ready_in_flush", alloc_ready, 1);
    step();
    flush       = 1'b0;
    alloc_valid = 1'b0;
    chk("t6_count", count, 0);
    chk("t6_cvalid", commit_valid, 0);
    chk("t6_tail", alloc_tag, 0);
    step();
    chk("t6_no_commit", commit_valid, 0);
    chk("t6_empty", empty, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
